// File: rtl/mem_responder_pkg.sv
// Shared definitions for the data-memory responder and the MAR selector that drives it.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_t;

  // Reserved word addresses the MAR selector may emit; both ends must agree.
  localparam logic [31:0] ADDR_RSV_3FF = 32'h0000_03ff;
  localparam logic [31:0] ADDR_RSV_3FE = 32'h0000_03fe;
  localparam logic [31:0] ADDR_RSV_2A1 = 32'h0000_02a1;
  localparam logic [31:0] ADDR_RSV_2A3 = 32'h0000_02a3;
  localparam logic [31:0] ADDR_RSV_2A5 = 32'h0000_02a5;
  localparam logic [31:0] ADDR_RSV_2A7 = 32'h0000_02a7;
  localparam logic [31:0] ADDR_RSV_2A9 = 32'h0000_02a9;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous word RAM; dout only updates on an enabled read.
module mem_array #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      r_mem[addr] <= din;
    end
  end

  // Output register holds the last read word; only it is reset, not the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (en && !we) begin
      dout <= r_mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: accepts one request in IDLE, waits WAIT_STATES cycles, then responds.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       MAR_in,
  input  logic [DATA_W-1:0] MDR_in,
  input  logic              mem_rd,
  input  logic              mem_wr,
  output logic              mem_busy,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_err
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  req_t              r_req;
  logic              r_bad;

  logic              w_req;
  logic              w_bad_in;
  logic              w_idle;
  logic              w_enter_resp;
  logic              w_ram_en;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_din;

  assign w_req    = mem_rd | mem_wr;
  assign w_bad_in = (mem_rd & mem_wr) | (|MAR_in[31:ADDR_W]);
  assign w_idle   = (r_state == ST_IDLE);

  // With zero wait states the access happens on the acceptance edge itself,
  // so the RAM is fed straight from the inputs while IDLE.
  assign w_enter_resp = !reset &&
                        ((w_idle && w_req && (WS == 4'd0)) ||
                         ((r_state == ST_WAIT) && (r_cnt == 4'd1)));
  assign w_ram_en   = w_enter_resp && !(w_idle ? w_bad_in : r_bad);
  assign w_ram_we   = w_idle ? mem_wr : (r_req == REQ_WR);
  assign w_ram_addr = w_idle ? MAR_in[ADDR_W-1:0] : r_addr;
  assign w_ram_din  = w_idle ? MDR_in : r_din;

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk (clk),
    .rst (reset),
    .en  (w_ram_en),
    .we  (w_ram_we),
    .addr(w_ram_addr),
    .din (w_ram_din),
    .dout(mem_data_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_din     <= '0;
      r_req     <= REQ_RD;
      r_bad     <= 1'b0;
      mem_busy  <= 1'b0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          if (w_req) begin
            r_addr   <= MAR_in[ADDR_W-1:0];
            r_din    <= MDR_in;
            r_req    <= mem_wr ? REQ_WR : REQ_RD;
            r_bad    <= w_bad_in;
            r_cnt    <= WS;
            mem_busy <= 1'b1;
            if (WS == 4'd0) begin
              r_state   <= ST_RESP;
              mem_ready <= 1'b1;
              mem_err   <= w_bad_in;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state   <= ST_RESP;
            mem_ready <= 1'b1;
            mem_err   <= r_bad;
          end
        end
        ST_RESP: begin
          r_state   <= ST_IDLE;
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          mem_busy  <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          mem_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder: a WAIT_STATES=2 build and a WAIT_STATES=0 build.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic        clk = 1'b0;
  logic [1:0]  rst, rd, wr;
  logic [1:0]  busy, ready, err;
  logic [31:0] mar  [2];
  logic [31:0] mdr  [2];
  logic [31:0] dout [2];

  int total = 0;
  int bad   = 0;

  int unsigned ws [2] = '{2, 0};
  logic [31:0] model [2][1024];
  logic [31:0] last  [2];

  typedef struct {
    bit          err;
    logic [31:0] data;
    int          lat;
  } resp_t;
  resp_t sb [$];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_STATES(2)) u_dut_ws2 (
    .clk(clk), .reset(rst[0]), .MAR_in(mar[0]), .MDR_in(mdr[0]),
    .mem_rd(rd[0]), .mem_wr(wr[0]), .mem_busy(busy[0]), .mem_ready(ready[0]),
    .mem_data_out(dout[0]), .mem_err(err[0])
  );

  mem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .reset(rst[1]), .MAR_in(mar[1]), .MDR_in(mdr[1]),
    .mem_rd(rd[1]), .mem_wr(wr[1]), .mem_busy(busy[1]), .mem_ready(ready[1]),
    .mem_data_out(dout[1]), .mem_err(err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request, push its expected response, then wait for and score it.
  task automatic transact(input int d, input bit r, input bit w,
                          input logic [31:0] a, input logic [31:0] v, input bit hold);
    resp_t e, got;
    int    n;
    e.err = (r && w) || (a[31:10] != 22'd0);
    if (!e.err) begin
      if (w) model[d][a[9:0]] = v;
      else   last[d] = model[d][a[9:0]];
    end
    e.data = last[d];
    e.lat  = int'(ws[d]);
    sb.push_back(e);

    @(negedge clk);
    rd[d] = r; wr[d] = w; mar[d] = a; mdr[d] = v;
    @(posedge clk); #1;
    check("busy_after_accept", {31'd0, busy[d]}, 32'd1);
    if (!hold) begin rd[d] = 1'b0; wr[d] = 1'b0; end
    n = 0;
    while (!ready[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_seen", {31'd0, ready[d]}, 32'd1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("latency", n, got.lat);
      check("err", {31'd0, err[d]}, {31'd0, got.err});
      check("data_out", dout[d], got.data);
    end
    @(posedge clk); #1;
    check("ready_one_cycle", {31'd0, ready[d]}, 32'd0);
    check("busy_released", {31'd0, busy[d]}, 32'd0);
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  initial begin
    bit seen;
    rst = 2'b11; rd = '0; wr = '0;
    mar[0] = '0; mar[1] = '0; mdr[0] = '0; mdr[1] = '0;
    last[0] = '0; last[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_busy",  {31'd0, busy[d]},  32'd0);
      check("rst_ready", {31'd0, ready[d]}, 32'd0);
      check("rst_err",   {31'd0, err[d]},   32'd0);
      check("rst_dout",  dout[d], 32'd0);
    end
    @(negedge clk);
    rst = 2'b00;

    transact(0, 0, 1, ADDR_RSV_3FF, 32'hDEAD_BEEF, 0);
    transact(0, 1, 0, ADDR_RSV_3FF, 32'h0, 0);
    transact(0, 0, 1, ADDR_RSV_2A1, 32'h1111_1111, 0);
    transact(0, 0, 1, ADDR_RSV_2A3, 32'h2222_2222, 0);
    transact(0, 1, 0, ADDR_RSV_2A1, 32'h0, 1);
    transact(0, 1, 0, ADDR_RSV_2A3, 32'h0, 0);
    transact(0, 0, 1, ADDR_RSV_2A5, 32'h55AA_55AA, 0);
    transact(0, 0, 1, ADDR_RSV_2A7, 32'h0BAD_C0DE, 0);
    transact(0, 1, 0, 32'h0000_0400, 32'h0, 0);
    transact(0, 1, 1, ADDR_RSV_2A5, 32'hFFFF_FFFF, 0);
    transact(0, 1, 0, ADDR_RSV_2A5, 32'h0, 0);

    // Abort a write with reset on the edge that would commit it.
    @(negedge clk);
    wr[0] = 1'b1; mar[0] = ADDR_RSV_2A7; mdr[0] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    wr[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    last[0] = '0;
    check("abort_busy",  {31'd0, busy[0]},  32'd0);
    check("abort_ready", {31'd0, ready[0]}, 32'd0);
    check("abort_err",   {31'd0, err[0]},   32'd0);
    check("abort_dout",  dout[0], 32'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ready[0]) seen = 1'b1;
    end
    check("abort_no_ready", {31'd0, seen}, 32'd0);
    transact(0, 1, 0, ADDR_RSV_2A7, 32'h0, 0);

    transact(1, 0, 1, ADDR_RSV_3FE, 32'h1234_5678, 0);
    transact(1, 1, 0, ADDR_RSV_3FE, 32'h0, 0);
    transact(1, 1, 0, 32'h0001_03FE, 32'h0, 0);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
